imem_prog_loader: RTL

- Byte-stream program loader: the writer side of the instruction memory that the fetch stage reads.
- Accepts a length-prefixed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes the words sequentially into the instruction-memory write port.
- Holds the CPU pipeline (cpu_hold) for the whole load, then releases it with a done pulse.

---
 rtl/imem_prog_loader.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/imem_prog_loader.sv
//==============================================================================
// Module  : imem_prog_loader
// Purpose : Byte-stream program loader. It is the writer side of the
//           instruction memory that the fetch stage reads. It accepts a
//           length-prefixed byte stream (16-bit little-endian word count N,
//           then 4*N data bytes), assembles little-endian 32-bit words and
//           writes them to consecutive word addresses starting at BASE_ADDR.
//           The CPU is held for the whole load and released together with
//           the done pulse.
// Ports   : clk          - system clock, rising edge
//           rst          - asynchronous active-low reset
//           start        - single-cycle load request (honoured in IDLE/DONE/ERR)
//           byte_valid   - byte_data is valid
//           byte_data    - stream byte
//           byte_ready   - loader accepts a byte this cycle
//           imem_we      - instruction-memory write strobe (one cycle per word)
//           imem_addr    - word address of the write
//           imem_wdata   - instruction word
//           cpu_hold     - stall request to the CPU
//           done         - one-cycle pulse, load completed successfully
//           err          - error flag, held until the next start
//           words_loaded - words written in the current load
// Option  : LOADER_CHECKSUM_EN - when defined, one checksum byte (XOR of all
//           data bytes) follows the data and is verified before DONE.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module imem_prog_loader #(
   parameter int                ADDR_W    = 10,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output logic [15:0]       words_loaded
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LEN_LO = 3'd1;
   localparam logic [2:0] S_LEN_HI = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
`ifdef LOADER_CHECKSUM_EN
   localparam logic [2:0] S_CSUM   = 3'd4;
`endif
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_ERR    = 3'd6;

   // Memory capacity in words, one bit wider than the length field so that
   // ADDR_W=16 still compares correctly.
   localparam logic [16:0] CAP = 17'd1 << ADDR_W;

   logic [2:0]        state_q, state_d;
   logic [15:0]       len_q;
   logic [23:0]       word_q;        // lower three bytes of the word in flight
   logic [1:0]        bidx_q;
   logic [ADDR_W-1:0] addr_q;        // address of the next word to write
   logic [15:0]       words_q;
   logic              we_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [31:0]       wdata_q;
   logic              done_q;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        csum_q;
`endif

   logic        xfer;
   logic        start_ok;
   logic [15:0] len_n;
   logic        word_full;
   logic        last_word;

   assign xfer      = byte_valid && byte_ready;
   assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                (state_q == S_ERR));
   assign len_n     = {byte_data, len_q[7:0]};
   assign word_full = (state_q == S_DATA) && xfer && (bidx_q == 2'd3);
   // words_q still holds the count before this word's write
   assign last_word = word_full && ((words_q + 16'd1) == len_q);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) state_d = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (xfer) state_d = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (xfer) begin
               if (len_n == 16'd0)             state_d = S_DONE;
               else if ({1'b0, len_n} > CAP)   state_d = S_ERR;
               else                            state_d = S_DATA;
            end
         end
         S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
            if (last_word) state_d = S_CSUM;
`else
            if (last_word) state_d = S_DONE;
`endif
         end
`ifdef LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (xfer) state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic (state-decoded outputs)
   always_comb begin
      byte_ready = 1'b0;
      cpu_hold   = 1'b0;
      err        = 1'b0;
      case (state_q)
         S_LEN_LO, S_LEN_HI, S_DATA: begin
            byte_ready = 1'b1;
            cpu_hold   = 1'b1;
         end
`ifdef LOADER_CHECKSUM_EN
         S_CSUM: begin
            byte_ready = 1'b1;
            cpu_hold   = 1'b1;
         end
`endif
         S_ERR: begin
            cpu_hold = 1'b1;
            err      = 1'b1;
         end
         default: ;
      endcase
   end

   assign imem_we      = we_q;
   assign imem_addr    = waddr_q;
   assign imem_wdata   = wdata_q;
   assign done         = done_q;
   assign words_loaded = words_q;

   // Datapath: length capture, word assembly and write-port registers.
   // The write is registered on the 4th byte so imem_we appears one cycle
   // later while the next byte can already be accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_q   <= '0;
         word_q  <= '0;
         bidx_q  <= '0;
         addr_q  <= '0;
         words_q <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         we_q   <= word_full;
         // Pulse only on entry, so DONE can be held without repeating done
         done_q <= (state_d == S_DONE) && (state_q != S_DONE);

         if (start_ok) begin
            len_q   <= '0;
            bidx_q  <= '0;
            addr_q  <= BASE_ADDR;
            words_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
         end else if (xfer) begin
            case (state_q)
               S_LEN_LO: len_q[7:0]  <= byte_data;
               S_LEN_HI: len_q[15:8] <= byte_data;
               S_DATA: begin
                  bidx_q <= bidx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                  csum_q <= csum_q ^ byte_data;
`endif
                  case (bidx_q)
                     2'd0: word_q[7:0]   <= byte_data;
                     2'd1: word_q[15:8]  <= byte_data;
                     2'd2: word_q[23:16] <= byte_data;
                     default: begin
                        wdata_q <= {byte_data, word_q};
                        waddr_q <= addr_q;
                        addr_q  <= addr_q + ADDR_W'(1);
                        words_q <= words_q + 16'd1;
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule

`default_nettype wire
